// File: rtl/bsg_async_rptr_ctrl_pkg.sv
// Shared constants for the async FIFO read-pointer controller.
// Widths are always derived from lg_size_p inside the modules themselves.
package bsg_async_rptr_ctrl_pkg;

    localparam int LG_SIZE_DEFAULT = 5;

endpackage

// File: rtl/bsg_gray_to_binary.sv
// Parameterized Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above its position.
module bsg_gray_to_binary #(
    parameter int width_p = 6
) (
    input  logic [width_p-1:0] i_gray,
    output logic [width_p-1:0] o_binary
);

    always_comb begin
        o_binary = '0;
        for (int i = 0; i < width_p; i++) begin
            o_binary[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/bsg_async_rptr_ctrl.sv
// Read-side pointer control for an asynchronous FIFO: tracks occupancy against the
// synchronized write pointer and publishes a flopped Gray read pointer for the write side.
module bsg_async_rptr_ctrl
    import bsg_async_rptr_ctrl_pkg::*;
#(
    parameter int lg_size_p = LG_SIZE_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [lg_size_p:0]   w_ptr_gray_rsync_i,
    input  logic                 yumi_i,
    output logic                 v_o,
    output logic [lg_size_p-1:0] r_addr_o,
    output logic [lg_size_p:0]   r_ptr_binary_r_o,
    output logic [lg_size_p:0]   r_ptr_gray_r_o,
    output logic [lg_size_p:0]   count_o,
    output logic                 overflow_err_o
);

    localparam int pw = lg_size_p + 1;
    localparam logic [pw-1:0] Depth  = pw'(2 ** lg_size_p);
    localparam logic [pw-1:0] PtrOne = pw'(1);

    logic [pw-1:0] w_w_ptr_bin;
    logic [pw-1:0] r_w_ptr_bin;
    logic [pw-1:0] w_occ;
    logic [pw-1:0] w_r_ptr_next;
    logic          w_over;
    logic          w_pop;

    bsg_gray_to_binary #(
        .width_p (pw)
    ) u_gray_to_binary (
        .i_gray   (w_ptr_gray_rsync_i),
        .o_binary (w_w_ptr_bin)
    );

    // Occupancy is a modular difference; anything beyond Depth means the write side lapped us.
    always_comb begin
        w_occ        = r_w_ptr_bin - r_ptr_binary_r_o;
        w_over       = (w_occ > Depth);
        v_o          = (w_occ != '0) && !w_over && !overflow_err_o;
        count_o      = w_over ? '0 : w_occ;
        w_pop        = yumi_i && v_o;
        w_r_ptr_next = r_ptr_binary_r_o + PtrOne;
        r_addr_o     = r_ptr_binary_r_o[lg_size_p-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_w_ptr_bin      <= '0;
            r_ptr_binary_r_o <= '0;
            r_ptr_gray_r_o   <= '0;
            overflow_err_o   <= 1'b0;
        end else begin
            r_w_ptr_bin <= w_w_ptr_bin;
            if (w_over) begin
                overflow_err_o <= 1'b1;
            end
            // Gray pointer is flopped together with the binary one so it crosses glitch-free.
            if (w_pop) begin
                r_ptr_binary_r_o <= w_r_ptr_next;
                r_ptr_gray_r_o   <= w_r_ptr_next ^ (w_r_ptr_next >> 1);
            end
        end
    end

endmodule
